// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready flow control,
// synchronous flush and bubble gating of side-effect control bits.
// Optional feature macro: PIPE_STAGE_SKID_EN adds a second (skid) entry so
// in_ready is a pure register output with no path from out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  // main register may take a new beat when empty or when its beat leaves
  logic load_en;
  logic in_fire;
  assign load_en = ~out_valid | out_ready;
  assign in_fire = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // skid entry only fills when main is full, so it never blocks a free slot
  assign in_ready = ~skid_valid;

  // main register: flush, then drain skid first (ordering), then input
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (load_en) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_ctrl  <= skid_ctrl;
        out_data  <= skid_data;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end
  end

  // skid register: capture a beat arriving during a stall, empty on drain
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (load_en) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= in_ctrl;
      skid_data  <= in_data;
    end
  end
`else
  // single entry: accept whenever the held beat is leaving or there is none
  assign in_ready = load_en;

  // main register: flush drops everything, a bubble clears ctrl, data holds
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
    end else if (load_en) begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_ctrl  <= in_ctrl;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg; adapts to PIPE_STAGE_SKID_EN (capacity 1 or 2).
module tb_pipe_stage_reg;
  localparam int DATA_W = 69;
  localparam int CTRL_W = 3;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clock = 1'b0;
  logic              resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
  );

  always #5 clock = ~clock;

  // reference: the stage is a FIFO of capacity CAP; out_data remembers the
  // last beat shown at the head
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;
  beat_t             q[$];
  logic [DATA_W-1:0] last_data;

  function automatic logic model_ready();
    return (q.size() < CAP) || (CAP == 1 && out_ready);
  endfunction

  task automatic tick();
    logic rdy;
    @(posedge clock);
    rdy = model_ready();
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back('{ctrl: in_ctrl, data: in_data});
    end
    if (q.size() > 0) last_data = q[0].data;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    q.delete();
    last_data = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_state: got v=%b c=%b d=%h want 0", out_valid, out_ctrl, out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    // load a beat, then reset asynchronously in the middle of the high phase
    in_valid = 1'b1; in_ctrl = 3'b111; in_data = 69'h33; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 69'h33) begin
      errors++; $display("FAIL reset_preload: got v=%b d=%h want 1/33", out_valid, out_data);
    end
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_async: got v=%b c=%b d=%h want 0", out_valid, out_ctrl, out_data);
    end
    @(negedge clock);
    resetn = 1'b1; in_valid = 1'b0;
    q.delete(); last_data = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 3'b101; in_data = DATA_W'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 3'b101 || out_data !== DATA_W'(i)) begin
        errors++; $display("FAIL stream_out[%0d]: got v=%b c=%b d=%h want 1/101/%h", i, out_valid, out_ctrl, out_data, i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== 69'h8) begin
      errors++; $display("FAIL stream_tail: got v=%b c=%b d=%h want 0/0/8", out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 3'b001; in_data = 69'h5;
    tick();
    out_ready = 1'b0; in_ctrl = 3'b010; in_data = 69'h6;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== ((CAP == 2 && k == 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b", k, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== 3'b001 || out_data !== 69'h5) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b c=%b d=%h want 1/001/5", k, out_valid, out_ctrl, out_data);
      end
    end
    // release: with skid the 0x6 is already held, so stop offering it
    out_ready = 1'b1;
    in_valid = (CAP == 1);
    #1;
    checks++;
    if (in_ready !== (CAP == 1)) begin
      errors++; $display("FAIL stall_release_ready: got %b", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== 3'b010 || out_data !== 69'h6) begin
      errors++; $display("FAIL stall_second: got v=%b c=%b d=%h want 1/010/6", out_valid, out_ctrl, out_data);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_ready_back: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== 69'h6) begin
      errors++; $display("FAIL stall_drain: got v=%b c=%b d=%h want 0/0/6", out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 3'b100; in_data = 69'h11;
    tick();
    flush = 1'b1; in_ctrl = 3'b011; in_data = 69'h22;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_handshake: got %b want 1", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== 69'h11) begin
      errors++; $display("FAIL flush_out: got v=%b c=%b d=%h want 0/0/11", out_valid, out_ctrl, out_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 69'h11) begin
        errors++; $display("FAIL flush_ghost[%0d]: got v=%b d=%h want 0/11", k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    in_valid = 1'b0; in_ctrl = 3'b111; in_data = 69'h1ABCD;
    for (int k = 0; k < 4; k++) begin
      out_ready = k[0];
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin
        errors++; $display("FAIL bubble[%0d]: got v=%b c=%b d=%h want 0/0/0", k, out_valid, out_ctrl, out_data);
      end
    end
  endtask

  task automatic test_random();
    int shown = 0;
    logic [CTRL_W-1:0] ec;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 64) == 0;
      in_ctrl   = CTRL_W'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      #1;
      ec = (q.size() > 0) ? q[0].ctrl : '0;
      checks++;
      if (in_ready !== model_ready() || out_valid !== (q.size() > 0) ||
          out_ctrl !== ec || out_data !== last_data) begin
        errors++;
        if (shown < 20)
          $display("FAIL random[%0d]: got rdy=%b v=%b c=%b d=%h want rdy=%b v=%b c=%b d=%h",
                   n, in_ready, out_valid, out_ctrl, out_data, model_ready(), q.size() > 0, ec, last_data);
        shown++;
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0; last_data = '0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
